utopia_rx_cell_assembler: RTL and testbench



---
 rtl/utopia_rx_cell_assembler.sv | 177 +++++++++++++++++
 tb/tb_utopia_rx_cell_assembler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/utopia_rx_cell_assembler.sv
// Utopia Level-1 receive cell assembler: pulls 53-byte cells off the PHY byte bus and hands them to the core.
// Optional HEC check is compiled in with `define UTOPIA_HEC_CHECK_EN.
module utopia_rx_cell_assembler #(
  parameter int IfWidth   = 8,
  parameter int CellBytes = 53,
  parameter int CntWidth  = 16
) (
  input  logic                           clk_in,
  input  logic                           reset,
  input  logic                           clav,
  input  logic                           soc,
  input  logic [IfWidth-1:0]             data,
  output logic                           en,
  output logic [CellBytes*IfWidth-1:0]   ATMcell,
  output logic                           valid,
  input  logic                           ready,
  output logic [CntWidth-1:0]            cell_count,
  output logic [CntWidth-1:0]            sync_err_count,
  output logic [CntWidth-1:0]            hec_err_count,
  output logic [1:0]                     state_dbg
);

  localparam int CellW = CellBytes * IfWidth;
  localparam int IdxW  = $clog2(CellBytes);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CellBytes - 1);

  if (IfWidth != 8) begin : g_if_width_check
    $error("utopia_rx_cell_assembler: only IfWidth == 8 is supported");
  end

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [CellW-1:0]    cell_q, cell_d;
  logic                valid_q, valid_d;
  logic [CntWidth-1:0] cell_cnt_q, cell_cnt_d;
  logic [CntWidth-1:0] sync_cnt_q, sync_cnt_d;
  logic                xfer;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] c);
    return (&c) ? c : c + CntWidth'(1);
  endfunction

`ifdef UTOPIA_HEC_CHECK_EN
  logic [7:0]          crc_q, crc_d;
  logic [7:0]          hec_q, hec_d;
  logic [CntWidth-1:0] hec_cnt_q, hec_cnt_d;

  // CRC-8, polynomial x^8+x^2+x+1, MSB first, one byte per call.
  function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  // Handshakes: a PHY byte moves on every rising edge with en==0 (en is
  // active-low and combinational from clav and state); a cell moves to the
  // core on every rising edge with valid==1 and ready==1. ready alone is ignored.
  assign en   = reset | ~(clav & (state_q != HOLD));
  assign xfer = ~en;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cell_d     = cell_q;
    valid_d    = valid_q;
    cell_cnt_d = cell_cnt_q;
    sync_cnt_d = sync_cnt_q;
`ifdef UTOPIA_HEC_CHECK_EN
    crc_d      = crc_q;
    hec_d      = hec_q;
    hec_cnt_d  = hec_cnt_q;
`endif
    case (state_q)
      HUNT: begin
        if (xfer && soc) begin
          cell_d  = {{(CellW-IfWidth){1'b0}}, data};
          idx_d   = IdxW'(1);
          state_d = RECV;
`ifdef UTOPIA_HEC_CHECK_EN
          crc_d   = crc8(8'h00, data);
`endif
        end
      end
      RECV: begin
        if (xfer && soc) begin
          // Framing slip: the partial cell is dropped and this byte starts a new one.
          sync_cnt_d = sat_inc(sync_cnt_q);
          cell_d     = {{(CellW-IfWidth){1'b0}}, data};
          idx_d      = IdxW'(1);
`ifdef UTOPIA_HEC_CHECK_EN
          crc_d      = crc8(8'h00, data);
`endif
        end else if (xfer) begin
          cell_d = {cell_q[CellW-IfWidth-1:0], data};
          idx_d  = idx_q + IdxW'(1);
`ifdef UTOPIA_HEC_CHECK_EN
          if (idx_q < IdxW'(4)) crc_d = crc8(crc_q, data);
          if (idx_q == IdxW'(4)) hec_d = data;
`endif
          if (idx_q == LastIdx) begin
            idx_d   = '0;
`ifdef UTOPIA_HEC_CHECK_EN
            if (hec_q != (crc_q ^ 8'h55)) begin
              hec_cnt_d = sat_inc(hec_cnt_q);
              state_d   = HUNT;
            end else begin
              valid_d = 1'b1;
              state_d = HOLD;
            end
`else
            valid_d = 1'b1;
            state_d = HOLD;
`endif
          end
        end
      end
      HOLD: begin
        if (ready) begin
          valid_d    = 1'b0;
          cell_cnt_d = sat_inc(cell_cnt_q);
          state_d    = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= HUNT;
      idx_q      <= '0;
      cell_q     <= '0;
      valid_q    <= 1'b0;
      cell_cnt_q <= '0;
      sync_cnt_q <= '0;
`ifdef UTOPIA_HEC_CHECK_EN
      crc_q      <= '0;
      hec_q      <= '0;
      hec_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cell_q     <= cell_d;
      valid_q    <= valid_d;
      cell_cnt_q <= cell_cnt_d;
      sync_cnt_q <= sync_cnt_d;
`ifdef UTOPIA_HEC_CHECK_EN
      crc_q      <= crc_d;
      hec_q      <= hec_d;
      hec_cnt_q  <= hec_cnt_d;
`endif
    end
  end

  assign ATMcell        = cell_q;
  assign valid          = valid_q;
  assign cell_count     = cell_cnt_q;
  assign sync_err_count = sync_cnt_q;
  assign state_dbg      = state_q;
`ifdef UTOPIA_HEC_CHECK_EN
  assign hec_err_count  = hec_cnt_q;
`else
  assign hec_err_count  = '0;
`endif

endmodule

// File: tb/tb_utopia_rx_cell_assembler.sv
// Self-checking bench for utopia_rx_cell_assembler: directed scenarios plus random cells
// compared against a byte-array reference model.
module tb_utopia_rx_cell_assembler;

  logic         clk_in = 1'b0;
  logic         reset;
  logic         clav;
  logic         soc;
  logic [7:0]   data;
  logic         ready;
  logic         en;
  logic [423:0] atm_cell;
  logic         valid;
  logic [15:0]  cell_count;
  logic [15:0]  sync_err_count;
  logic [15:0]  hec_err_count;
  logic [1:0]   state_dbg;

  utopia_rx_cell_assembler dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .clav           (clav),
    .soc            (soc),
    .data           (data),
    .en             (en),
    .ATMcell        (atm_cell),
    .valid          (valid),
    .ready          (ready),
    .cell_count     (cell_count),
    .sync_err_count (sync_err_count),
    .hec_err_count  (hec_err_count),
    .state_dbg      (state_dbg)
  );

  always #5 clk_in = ~clk_in;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]   cell_b [53];
  logic [423:0] exp_q [$];
  logic [15:0]  exp_cells, exp_sync, exp_hec;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [423:0] obs, input logic [423:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference cell: byte k lands in bits [423-8k -: 8].
  function automatic logic [423:0] model_cell();
    logic [423:0] r;
    r = '0;
    for (int k = 0; k < 53; k++) r[423-8*k -: 8] = cell_b[k];
    return r;
  endfunction

  // HEC = (header * x^8 mod x^8+x^2+x+1) XOR 0x55, by long division over the whole header.
  function automatic logic [7:0] model_hec(input logic [31:0] hdr);
    logic [39:0] r;
    r = {hdr, 8'h00};
    for (int b = 39; b >= 8; b--) begin
      if (r[b]) r = r ^ (40'h107 << (b - 8));
    end
    return r[7:0] ^ 8'h55;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < 53; k++) cell_b[k] = 8'($urandom_range(0, 255));
`ifdef UTOPIA_HEC_CHECK_EN
    cell_b[4] = model_hec({cell_b[0], cell_b[1], cell_b[2], cell_b[3]});
`endif
  endtask

  // Entered and left just after a falling edge; one transfer per cycle unless paused.
  task automatic send_bytes(input int n, input int pause_after, input int pause_len);
    for (int k = 0; k < n; k++) begin
      clav = 1'b1;
      soc  = (k == 0);
      data = cell_b[k];
      #1;
      chk1("en_during_xfer", en, 1'b0);
      @(negedge clk_in);
      if (k == pause_after) begin
        clav = 1'b0;
        soc  = 1'b0;
        for (int p = 0; p < pause_len; p++) begin
          #1;
          chk1("en_during_pause", en, 1'b1);
          @(negedge clk_in);
        end
      end
    end
    clav = 1'b0;
    soc  = 1'b0;
  endtask

  task automatic send_junk(input int n);
    for (int k = 0; k < n; k++) begin
      clav = 1'b1;
      soc  = 1'b0;
      data = 8'($urandom_range(0, 255));
      @(negedge clk_in);
    end
    clav = 1'b0;
  endtask

  task automatic expect_delivery(input int hold);
    logic [423:0] exp;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    exp = exp_q.pop_front();
    #1;
    chk1("valid_rise", valid, 1'b1);
    chkw("cell_data", atm_cell, exp);
    clav = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_in);
      #1;
      chk1("valid_hold", valid, 1'b1);
      chk1("en_hold", en, 1'b1);
      chkw("cell_stable", atm_cell, exp);
    end
    ready = 1'b1;
    @(negedge clk_in);
    #1;
    exp_cells++;
    chk1("valid_fall", valid, 1'b0);
    chk16("cell_count", cell_count, exp_cells);
    chk1("en_after_accept", en, 1'b0);
    clav  = 1'b0;
    ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clav = 1'b1; soc = 1'b0; data = 8'h00; ready = 1'b0;
    exp_cells = '0; exp_sync = '0; exp_hec = '0;
    repeat (3) @(negedge clk_in);
    #1;
    chk1("reset_en", en, 1'b1);
    chk1("reset_valid", valid, 1'b0);
    chkw("reset_cell", atm_cell, 424'd0);
    chk16("reset_cell_count", cell_count, 16'd0);
    chk16("reset_sync_count", sync_err_count, 16'd0);
    chk16("reset_hec_count", hec_err_count, 16'd0);
    clav = 1'b0;
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);

    // Single cell 0x00..0x34 with ready held high.
    for (int k = 0; k < 53; k++) cell_b[k] = 8'(k);
`ifdef UTOPIA_HEC_CHECK_EN
    cell_b[4] = model_hec(32'h00010203);
`endif
    ready = 1'b1;
    send_bytes(53, -1, 0);
    exp_q.push_back(model_cell());
    chk16("first_byte", {8'h00, atm_cell[423:416]}, 16'h0000);
    chk16("last_byte", {8'h00, atm_cell[7:0]}, 16'h0034);
    expect_delivery(0);

    // Back-pressure for 20 cycles.
    fill_random();
    send_bytes(53, -1, 0);
    exp_q.push_back(model_cell());
    expect_delivery(20);

    // Pause of 5 cycles after byte 10.
    fill_random();
    send_bytes(53, 10, 5);
    exp_q.push_back(model_cell());
    expect_delivery(2);
    chk16("pause_sync_count", sync_err_count, exp_sync);

    // Resync: soc arrives where byte 30 of a cell was due.
    fill_random();
    send_bytes(30, -1, 0);
    fill_random();
    send_bytes(53, -1, 0);
    exp_sync++;
    exp_q.push_back(model_cell());
    chk16("resync_sync_count", sync_err_count, exp_sync);
    expect_delivery(1);

`ifdef UTOPIA_HEC_CHECK_EN
    for (int k = 0; k < 53; k++) cell_b[k] = 8'($urandom_range(0, 255));
    cell_b[0] = 8'h00; cell_b[1] = 8'h00; cell_b[2] = 8'h00; cell_b[3] = 8'h00;
    cell_b[4] = 8'h55;
    send_bytes(53, -1, 0);
    exp_q.push_back(model_cell());
    expect_delivery(0);
    cell_b[4] = 8'h54;
    send_bytes(53, -1, 0);
    exp_hec++;
    #1;
    chk1("hec_bad_valid", valid, 1'b0);
    chk16("hec_err_count", hec_err_count, exp_hec);
    clav = 1'b1;
    #1;
    chk1("hec_bad_en", en, 1'b0);
    clav = 1'b0;
    @(negedge clk_in);
`else
    chk16("hec_count_tied", hec_err_count, 16'd0);
`endif

    // Reset in the middle of a cell.
    fill_random();
    send_bytes(20, -1, 0);
    reset = 1'b1;
    clav  = 1'b1;
    #1;
    chk1("midreset_en", en, 1'b1);
    @(negedge clk_in);
    reset = 1'b0;
    clav  = 1'b0;
    exp_cells = '0; exp_sync = '0; exp_hec = '0;
    #1;
    chk1("midreset_valid", valid, 1'b0);
    chk16("midreset_cell_count", cell_count, 16'd0);
    chk16("midreset_sync_count", sync_err_count, 16'd0);
    chk16("midreset_hec_count", hec_err_count, 16'd0);
    @(negedge clk_in);
    fill_random();
    send_bytes(53, -1, 0);
    exp_q.push_back(model_cell());
    expect_delivery(0);

    // Random cells with idle junk, pauses and back-pressure.
    for (int c = 0; c < 8; c++) begin
      send_junk($urandom_range(0, 3));
      fill_random();
      send_bytes(53, $urandom_range(0, 51), $urandom_range(0, 4));
      exp_q.push_back(model_cell());
      expect_delivery($urandom_range(0, 5));
    end
    chk16("final_sync_count", sync_err_count, exp_sync);
    chk16("final_hec_count", hec_err_count, exp_hec);
    chk16("scoreboard_left", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
